// File: rtl/fifo_stream_reader_if.sv
// Handshake bundle for the FIFO read-side master.
// It carries the FIFO pop port (rd_en/dout/empty) and the downstream
// valid/ready stream. The master modport is the reader's view, and the
// slave modport is the environment's view (FIFO plus sink).
interface fifo_stream_reader_if #(
  parameter int DATA_W = 8
);
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_rd_en;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_ready;

  modport master (
    input  fifo_empty,
    input  fifo_dout,
    input  m_ready,
    output fifo_rd_en,
    output m_valid,
    output m_data
  );

  modport slave (
    output fifo_empty,
    output fifo_dout,
    output m_ready,
    input  fifo_rd_en,
    input  m_valid,
    input  m_data
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Read-side master for a synchronous FIFO with a 1-cycle registered read.
// It pops words into a 2-entry skid buffer and presents them as a valid/ready
// stream. A read is only issued when the word it returns is guaranteed a slot.
// That rule lets a continuously ready sink receive one word per clock.
module fifo_stream_reader #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  fifo_stream_reader_if.master bus,
  output logic [CNT_W-1:0]     pop_count,
  output logic                 idle
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_t;

  buf_state_t        state_reg, state_next;
  logic [DATA_W-1:0] head_reg, head_next;
  logic [DATA_W-1:0] tail_reg, tail_next;
  logic              inflight_reg;
  logic [CNT_W-1:0]  pop_count_reg;

  logic              wr;
  logic              pop;
  logic [1:0]        buf_cnt;
  logic [1:0]        occ;
  logic [1:0]        occ_after_pop;

  // A word arrives from the FIFO exactly one cycle after its read strobe.
  assign wr  = inflight_reg;
  assign pop = bus.m_valid && bus.m_ready;

  // Translate the buffer state into a word count for the read-issue rule.
  always_comb begin
    buf_cnt = 2'd0;
    case (state_reg)
      EMPTY:   buf_cnt = 2'd0;
      ONE:     buf_cnt = 2'd1;
      TWO:     buf_cnt = 2'd2;
      default: buf_cnt = 2'd0;
    endcase
  end

  assign occ           = buf_cnt + {1'b0, inflight_reg};
  assign occ_after_pop = occ - {1'b0, pop};

  // Issue a read only if the returning word will still fit after this cycle's pop.
  // The read is gated by rst_n so that no read is issued while reset is held.
  assign bus.fifo_rd_en = rst_n && en && !bus.fifo_empty && (occ_after_pop < 2'd2);

  assign bus.m_valid = (state_reg != EMPTY);
  assign bus.m_data  = head_reg;
  assign pop_count   = pop_count_reg;
  assign idle        = (state_reg == EMPTY) && !inflight_reg;

  // Next-state logic for the skid buffer: a write, a pop, or both at once.
  always_comb begin
    state_next = state_reg;
    head_next  = head_reg;
    tail_next  = tail_reg;
    case (state_reg)
      EMPTY: begin
        if (wr) begin
          head_next  = bus.fifo_dout;
          state_next = ONE;
        end
      end
      ONE: begin
        if (wr && pop) begin
          head_next = bus.fifo_dout;
        end else if (wr) begin
          tail_next  = bus.fifo_dout;
          state_next = TWO;
        end else if (pop) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        // A write without a pop cannot happen here, because the read rule blocks it.
        if (pop) begin
          head_next = tail_reg;
          if (wr) begin
            tail_next = bus.fifo_dout;
          end else begin
            state_next = ONE;
          end
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // Update the buffer state and data registers.
  // Reset discards any buffered word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= EMPTY;
      head_reg  <= '0;
      tail_reg  <= '0;
    end else begin
      state_reg <= state_next;
      head_reg  <= head_next;
      tail_reg  <= tail_next;
    end
  end

  // Track the outstanding FIFO read. Reset drops any word still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_reg <= 1'b0;
    end else begin
      inflight_reg <= bus.fifo_rd_en;
    end
  end

  // Count accepted beats. The counter wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pop_count_reg <= '0;
    end else begin
      pop_count_reg <= pop_count_reg + {{(CNT_W-1){1'b0}}, pop};
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a queue-based FIFO model feeds the reader.
// The expected stream comes from the words actually popped from that FIFO.
// Every cycle the outputs are compared against the occupancy rules.
module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        wr_req;
  logic [7:0]  wr_data;
  logic [15:0] pop_count;
  logic        idle;

  fifo_stream_reader_if #(.DATA_W(8)) bus ();

  fifo_stream_reader #(.DATA_W(8), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .bus       (bus),
    .pop_count (pop_count),
    .idle      (idle)
  );

  always #5 clk = ~clk;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] popped_word;
  int         pops_m;
  bit         inflight_m;
  int         pass_cnt = 0;
  int         chk_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    chk_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
  endtask

  // FIFO model plus reader model. exp_q holds every word the reader owns,
  // including the one in flight. Reset empties the reader, but the FIFO keeps its contents.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      inflight_m = 1'b0;
      pops_m     = 0;
      bus.fifo_empty <= (fifo_q.size() == 0);
    end else begin
      if (((exp_q.size() - int'(inflight_m)) > 0) && bus.m_ready) begin
        void'(exp_q.pop_front());
        pops_m++;
      end
      if (bus.fifo_rd_en && fifo_q.size() > 0) begin
        popped_word = fifo_q.pop_front();
        bus.fifo_dout <= popped_word;
        exp_q.push_back(popped_word);
      end
      inflight_m = bus.fifo_rd_en;
      if (wr_req) fifo_q.push_back(wr_data);
      bus.fifo_empty <= (fifo_q.size() == 0);
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      int occ;
      bit ev, ep, er;
      occ = exp_q.size();
      ev  = (occ - int'(inflight_m)) > 0;
      ep  = ev && bus.m_ready;
      er  = en && !bus.fifo_empty && ((occ - int'(ep)) < 2);
      check("m_valid", bus.m_valid, ev);
      if (ev) check("m_data", bus.m_data, exp_q[0]);
      check("rd_en", bus.fifo_rd_en, er);
      check("idle", idle, occ == 0);
      check("pop_count", pop_count, pops_m[15:0]);
    end
  end

  task automatic preload(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wr_req  = 1'b1;
      wr_data = base + 8'(i);
    end
    @(negedge clk);
    wr_req = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    wr_req = 1'b0; en = 1'b1; bus.m_ready = 1'b1;
    do begin
      @(negedge clk); #3;
      t++;
    end while (!(idle && fifo_q.size() == 0) && t < 300);
    check(name, t < 300, 1);
  endtask

  initial begin
    logic [7:0] held;
    int pulses;
    rst_n = 1'b0; en = 1'b0; wr_req = 1'b0; wr_data = 8'h00; bus.m_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Single word: the read strobe comes first, the beat follows two cycles later, then idle.
    @(negedge clk); wr_req = 1'b1; wr_data = 8'hA5;
    @(negedge clk); wr_req = 1'b0; en = 1'b1; bus.m_ready = 1'b1;
    #3 check("t2_rd_en", bus.fifo_rd_en, 1);
    @(negedge clk); #3 check("t2_gap_valid", bus.m_valid, 0);
    @(negedge clk); #3 check("t2_valid", bus.m_valid, 1);
    check("t2_data", bus.m_data, 8'hA5);
    @(negedge clk); #3 check("t2_pop_count", pop_count, 1);
    check("t2_idle", idle, 1);
    $display("t2 single word done, pop_count=%0d", pop_count);

    // Streaming: 16 back-to-back beats 00..0F.
    en = 1'b0;
    preload(8'h00, 16);
    en = 1'b1; bus.m_ready = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      #3 check("t3_valid", bus.m_valid, 1);
      check("t3_data", bus.m_data, i);
      @(negedge clk);
    end
    #3 check("t3_pop_count", pop_count, 17);
    check("t3_idle", idle, 1);
    $display("t3 streaming done, pop_count=%0d", pop_count);

    // Backpressure: hold the sink off for 10 cycles mid-stream.
    en = 1'b0;
    preload(8'h20, 16);
    en = 1'b1; bus.m_ready = 1'b1;
    repeat (4) @(negedge clk);
    bus.m_ready = 1'b0;
    #3 held = bus.m_data;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus.fifo_rd_en) pulses++;
      check("t4_hold_valid", bus.m_valid, 1);
      check("t4_hold_data", bus.m_data, held);
      @(negedge clk); #3;
    end
    check("t4_rd_pulses_le2", pulses <= 2, 1);
    drain("t4_drain_timeout");
    check("t4_pop_count", pop_count, 33);
    $display("t4 backpressure done, held=%0h pulses=%0d", held, pulses);

    // en drop with one read in flight: exactly that word is delivered.
    en = 1'b0;
    preload(8'h40, 8);
    en = 1'b1; bus.m_ready = 1'b1;
    #3 check("t5_rd_en", bus.fifo_rd_en, 1);
    @(negedge clk); en = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #3 check("t5_no_rd", bus.fifo_rd_en, 0);
      @(negedge clk);
    end
    #3 check("t5_idle", idle, 1);
    check("t5_pop_count", pop_count, 34);
    check("t5_fifo_left", fifo_q.size(), 7);
    $display("t5 en drop done, fifo_left=%0d", fifo_q.size());

    // Asynchronous reset while streaming.
    @(negedge clk); en = 1'b1; bus.m_ready = 1'b1;
    repeat (3) @(negedge clk);
    #3 check("t1_pre_valid", bus.m_valid, 1);
    rst_n = 1'b0;
    #1 check("t1_rd_en", bus.fifo_rd_en, 0);
    check("t1_m_valid", bus.m_valid, 0);
    check("t1_pop_count", pop_count, 0);
    check("t1_idle", idle, 1);
    repeat (2) @(negedge clk);
    en = 1'b0; bus.m_ready = 1'b0;
    rst_n = 1'b1;
    $display("t1 async reset done");

    // Random traffic with a mid-run reset pulse.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      wr_req      = ($urandom % 2) == 0;
      wr_data     = 8'($urandom);
      en          = ($urandom % 4) != 0;
      bus.m_ready = ($urandom % 3) != 0;
      if (i == 50) begin
        wr_req = 1'b0;
        #3 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    drain("t6_drain_timeout");
    check("t6_idle", idle, 1);
    $display("t6 random done, pop_count=%0d", pop_count);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
